// File: rtl/fetch_queue_pkg.sv
// Shared pipeline types for the fetch/decode boundary.
package fetch_queue_pkg;

   localparam int unsigned XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

   typedef struct packed {
      logic [XLEN-1:0] instruction;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: in-order, show-ahead head,
// single-cycle flush on redirect. NOP and pc 0 are presented while empty.
module fetch_queue #(
   parameter int unsigned XLEN  = fetch_queue_pkg::XLEN,  // must match the package entry width
   parameter int unsigned DEPTH = 4                        // power of two, >= 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        flush,
   input  logic                        fetch_valid,
   input  logic [XLEN-1:0]             fetch_instruction,
   input  logic [XLEN-1:0]             fetch_pc,
   output logic                        fetch_ready,
   output logic                        dec_valid,
   output logic [XLEN-1:0]             dec_instruction,
   output logic [XLEN-1:0]             dec_pc,
   input  logic                        dec_ready,
   output logic [$clog2(DEPTH):0]      occupancy
);

   import fetch_queue_pkg::*;

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   fetch_entry_t     storage [DEPTH];
   fetch_entry_t     head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             push;
   logic             pop;

   // Handshake flags decode registered count only; no dec_ready -> fetch_ready path.
   assign fetch_ready = (count != FULL_COUNT);
   assign dec_valid   = (count != '0);
   assign occupancy   = count;

   assign push = fetch_valid && fetch_ready && !flush;
   assign pop  = dec_valid && dec_ready && !flush;

   // Next occupancy from the accepted handshakes.
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   // Pointer and count registers; flush empties the queue in one edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_next;
      end
   end

   // Entry storage; contents are don't-care out of reset.
   always_ff @(posedge clk) begin
      if (push) begin
         storage[wr_ptr] <= '{instruction: fetch_instruction, pc: fetch_pc};
      end
   end

   // Show-ahead head, forced to NOP/pc 0 while empty so decode never sees stale data.
   always_comb begin
      head = storage[rd_ptr];
      if (!dec_valid) begin
         head = '{instruction: NOP_INSTR, pc: '0};
      end
   end

   assign dec_instruction = head.instruction;
   assign dec_pc          = head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the driver queues expected words as it
// issues them, the monitor checks every word decode consumes.
`timescale 1ns/1ps
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        fetch_valid;
   logic [31:0] fetch_instruction;
   logic [31:0] fetch_pc;
   logic        fetch_ready;
   logic        dec_valid;
   logic [31:0] dec_instruction;
   logic [31:0] dec_pc;
   logic        dec_ready;
   logic [2:0]  occupancy;

   int n_cmp = 0;
   int n_bad = 0;
   fetch_entry_t exp_q[$];

   always #5 clk = ~clk;

   fetch_queue #(.XLEN(32), .DEPTH(4)) dut (
      .clk               (clk),
      .reset             (reset),
      .flush             (flush),
      .fetch_valid       (fetch_valid),
      .fetch_instruction (fetch_instruction),
      .fetch_pc          (fetch_pc),
      .fetch_ready       (fetch_ready),
      .dec_valid         (dec_valid),
      .dec_instruction   (dec_instruction),
      .dec_pc            (dec_pc),
      .dec_ready         (dec_ready),
      .occupancy         (occupancy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a word on fetch and record it as expected at decode.
   task automatic offer(input logic [31:0] pc);
      fetch_valid       = 1'b1;
      fetch_pc          = pc;
      fetch_instruction = 32'hA000_0000 | pc;
      exp_q.push_back('{instruction: 32'hA000_0000 | pc, pc: pc});
   endtask

   task automatic check_empty(input string tag);
      check({tag, "_dec_valid"},   32'(dec_valid),   32'd0);
      check({tag, "_dec_instr"},   dec_instruction,  32'h0000_0013);
      check({tag, "_dec_pc"},      dec_pc,           32'd0);
      check({tag, "_fetch_ready"}, 32'(fetch_ready), 32'd1);
      check({tag, "_occupancy"},   32'(occupancy),   32'd0);
   endtask

   // Monitor: sampled at negedge, ahead of the edge where a pop would take effect.
   always @(negedge clk) begin
      fetch_entry_t e;
      if (reset === 1'b0) begin
         check("inv_ready_vs_occ", 32'(fetch_ready), 32'(occupancy != 3'd4));
         check("inv_valid_vs_occ", 32'(dec_valid),   32'(occupancy != 3'd0));
         check("inv_occ_range",    32'(occupancy <= 3'd4), 32'd1);
         if (!dec_valid) begin
            check("idle_nop", dec_instruction, 32'h0000_0013);
            check("idle_pc",  dec_pc,          32'd0);
         end else if (dec_ready && !flush) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_unexpected_pop: got pc %h, required no word", dec_pc);
            end else begin
               e = exp_q.pop_front();
               check("head_instr", dec_instruction, e.instruction);
               check("head_pc",    dec_pc,          e.pc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset             = 1'b1;
      flush             = 1'b0;
      fetch_valid       = 1'b0;
      fetch_instruction = '0;
      fetch_pc          = '0;
      dec_ready         = 1'b0;

      // Reset then idle
      tick();
      check_empty("in_reset");
      tick();
      reset = 1'b0;
      tick();
      check_empty("after_reset");

      // Single pass
      fetch_valid       = 1'b1;
      fetch_instruction = 32'h0050_0093;
      fetch_pc          = 32'h0;
      exp_q.push_back('{instruction: 32'h0050_0093, pc: 32'h0});
      tick();
      fetch_valid = 1'b0;
      check("single_valid", 32'(dec_valid), 32'd1);
      check("single_instr", dec_instruction, 32'h0050_0093);
      check("single_pc",    dec_pc,          32'h0);
      check("single_occ",   32'(occupancy),  32'd1);
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      check("single_drain_occ",   32'(occupancy), 32'd0);
      check("single_drain_valid", 32'(dec_valid), 32'd0);

      // Fill and back-pressure
      for (int i = 0; i < 4; i++) begin
         offer(32'(4 * i));
         tick();
      end
      check("full_occ",   32'(occupancy),   32'd4);
      check("full_ready", 32'(fetch_ready), 32'd0);
      offer(32'h10);
      tick();
      check("full_hold_occ", 32'(occupancy), 32'd4);
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      check("pop_one_occ",   32'(occupancy),   32'd3);
      check("pop_one_ready", 32'(fetch_ready), 32'd1);
      tick();
      fetch_valid = 1'b0;
      check("refill_occ", 32'(occupancy), 32'd4);
      dec_ready = 1'b1;
      repeat (4) tick();
      dec_ready = 1'b0;
      check("drain_occ", 32'(occupancy), 32'd0);

      // Wrap-around streaming
      dec_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         offer(32'(4 * i));
         tick();
         check("stream_occ", 32'(occupancy), 32'd1);
      end
      fetch_valid = 1'b0;
      tick();
      dec_ready = 1'b0;
      check("stream_end_occ", 32'(occupancy), 32'd0);

      // Flush with simultaneous push and pop
      for (int i = 0; i < 3; i++) begin
         offer(32'h40 + 32'(4 * i));
         tick();
      end
      fetch_valid = 1'b0;
      check("preflush_occ", 32'(occupancy), 32'd3);
      flush             = 1'b1;
      fetch_valid       = 1'b1;
      fetch_pc          = 32'h4C;
      fetch_instruction = 32'hA000_004C;
      dec_ready         = 1'b1;
      exp_q.delete();
      tick();
      flush       = 1'b0;
      fetch_valid = 1'b0;
      dec_ready   = 1'b0;
      check("flush_occ",   32'(occupancy), 32'd0);
      check("flush_valid", 32'(dec_valid), 32'd0);
      check("flush_instr", dec_instruction, 32'h0000_0013);
      offer(32'h100);
      tick();
      fetch_valid = 1'b0;
      check("post_flush_head_pc", dec_pc, 32'h100);
      check("post_flush_occ",     32'(occupancy), 32'd1);
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;

      // Async reset mid-stream
      offer(32'h200);
      tick();
      offer(32'h204);
      tick();
      fetch_valid = 1'b0;
      check("prereset_occ", 32'(occupancy), 32'd2);
      #2;
      reset = 1'b1;
      exp_q.delete();
      #1;
      check_empty("async_reset");
      #1;
      reset = 1'b0;
      tick();
      check("post_reset_occ", 32'(occupancy), 32'd0);
      offer(32'h300);
      tick();
      fetch_valid = 1'b0;
      check("post_reset_head_pc", dec_pc, 32'h300);
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      tick();

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
